// File: rtl/mem_latency_injector.sv
// Timing-only memory model: accepts size-tagged requests and returns them in
// order after a base latency (SRAM, DRAM hit or DRAM miss) plus an optional
// pseudo-random extra latency. Carries no data, only the request size, and
// keeps saturating 32-bit performance counters.
module mem_latency_injector #(
  parameter int SIZE_WIDTH          = 16,
  parameter int LATENCY_SRAM_CYCLES = 5,
  parameter int LATENCY_DRAM_CYCLES = 12,
  parameter int QUEUE_DEPTH         = 1,
  parameter int EXTRA_LATENCY_MAX   = 0,
  parameter int LATENCY_DIST_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_is_dram,
  input  logic [SIZE_WIDTH-1:0] req_size_bytes,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [SIZE_WIDTH-1:0] resp_size_bytes,
  input  logic [15:0]           cfg_latency_sram,
  input  logic [15:0]           cfg_latency_dram,
  input  logic [9:0]            cfg_dram_hit_milli_pct,
  input  logic                  cfg_use_cfg_latencies,
  output logic [31:0]           total_reqs,
  output logic [31:0]           total_resp,
  output logic [31:0]           sram_reqs,
  output logic [31:0]           dram_reqs,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           busy_cycles,
  output logic                  busy
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int OCC_W = $clog2(QUEUE_DEPTH + 1);
  // 16-bit base plus an extra term that is always below 2^16 fits in 17 bits.
  localparam int CNT_W = 17;

  logic [SIZE_WIDTH-1:0] size_q [QUEUE_DEPTH];
  logic [CNT_W-1:0]      cnt_q  [QUEUE_DEPTH];

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic                  resp_valid_q;
  logic [SIZE_WIDTH-1:0] resp_size_q;
  logic [31:0]           total_reqs_q, total_resp_q, sram_reqs_q, dram_reqs_q;
  logic [31:0]           stall_cycles_q, busy_cycles_q;

  logic                  push, pop;
  logic [15:0]           lat_sram, lat_dram, lat_base;
  logic                  dram_hit;
  logic [CNT_W-1:0]      lat_extra, lat_total;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] extra_mod(input logic [15:0] v);
    return CNT_W'({16'd0, v} % 32'(EXTRA_LATENCY_MAX + 1));
  endfunction

  // Full is judged on registered occupancy only, so a pop never frees a slot
  // for a push in the same cycle.
  assign req_ready = (occ_q < OCC_W'(QUEUE_DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (occ_q != '0) && (cnt_q[head_q] == '0);
  assign busy      = (occ_q != '0);

  assign resp_valid      = resp_valid_q;
  assign resp_size_bytes = resp_size_q;
  assign total_reqs      = total_reqs_q;
  assign total_resp      = total_resp_q;
  assign sram_reqs       = sram_reqs_q;
  assign dram_reqs       = dram_reqs_q;
  assign stall_cycles    = stall_cycles_q;
  assign busy_cycles     = busy_cycles_q;

  // Latency of the request offered this cycle: base select, clamp, extra term.
  always_comb begin
    lat_sram  = cfg_use_cfg_latencies ? cfg_latency_sram : 16'(LATENCY_SRAM_CYCLES);
    lat_dram  = cfg_use_cfg_latencies ? cfg_latency_dram : 16'(LATENCY_DRAM_CYCLES);
    dram_hit  = (lfsr_q[9:0] % 10'd1000) < cfg_dram_hit_milli_pct;
    lat_base  = (req_is_dram && !dram_hit) ? lat_dram : lat_sram;
    if (lat_base == 16'd0) lat_base = 16'd1;
    lat_extra = (LATENCY_DIST_MODE == 1) ? extra_mod(lfsr_q) : '0;
    lat_total = {1'b0, lat_base} + lat_extra;
  end

  // Next-state for queue pointers, occupancy and the LFSR.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (push) tail_d = next_ptr(tail_q);
    if (pop)  head_d = next_ptr(head_q);
    if (push && !pop)      occ_d = occ_q + OCC_W'(1);
    else if (pop && !push) occ_d = occ_q - OCC_W'(1);
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Entry storage: every countdown runs to zero and parks there; a push
  // overwrites the tail slot. Validity comes from occupancy, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
    end
    if (push) begin
      size_q[tail_q] <= req_size_bytes;
      cnt_q[tail_q]  <= lat_total;
    end
  end

  // Control state, response register and performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q         <= '0;
      tail_q         <= '0;
      occ_q          <= '0;
      lfsr_q         <= 16'hACE1;
      resp_valid_q   <= 1'b0;
      resp_size_q    <= '0;
      total_reqs_q   <= '0;
      total_resp_q   <= '0;
      sram_reqs_q    <= '0;
      dram_reqs_q    <= '0;
      stall_cycles_q <= '0;
      busy_cycles_q  <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      occ_q        <= occ_d;
      lfsr_q       <= lfsr_d;
      resp_valid_q <= pop;
      if (pop) begin
        resp_size_q  <= size_q[head_q];
        total_resp_q <= sat_inc(total_resp_q);
      end
      if (push) begin
        total_reqs_q <= sat_inc(total_reqs_q);
        if (req_is_dram) dram_reqs_q <= sat_inc(dram_reqs_q);
        else             sram_reqs_q <= sat_inc(sram_reqs_q);
      end
      if (req_valid && !req_ready) stall_cycles_q <= sat_inc(stall_cycles_q);
      if (busy)                    busy_cycles_q  <= sat_inc(busy_cycles_q);
    end
  end

endmodule

// File: tb/tb_mem_latency_injector.sv
// Bench for mem_latency_injector: three instances (depth 1 fixed latency,
// depth 4 fixed latency, depth 1 with uniform extra latency) driven one at a
// time against a request-level reference model of latency and ordering.
module tb_mem_latency_injector;

  localparam int N = 3;

  typedef struct {
    int unsigned t;      // edge at which the response pulse is produced
    int unsigned acc_e;  // accepting edge
    logic [15:0] sz;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld [N];
  logic        is_dram;
  logic [15:0] size;
  logic [15:0] cfg_s, cfg_d;
  logic [9:0]  hit;
  logic        use_cfg;

  logic [N-1:0] rdy, rv, bsy;
  logic [15:0]  rs     [N];
  logic [31:0]  treq   [N];
  logic [31:0]  tresp  [N];
  logic [31:0]  sreq   [N];
  logic [31:0]  dreq   [N];
  logic [31:0]  stallc [N];
  logic [31:0]  busyc  [N];

  always #5 clk = ~clk;

  mem_latency_injector #(.SIZE_WIDTH(16), .LATENCY_SRAM_CYCLES(5), .LATENCY_DRAM_CYCLES(12),
    .QUEUE_DEPTH(1), .EXTRA_LATENCY_MAX(0), .LATENCY_DIST_MODE(0)) u0 (
    .clk(clk), .reset(rst_n), .req_valid(vld[0]), .req_is_dram(is_dram), .req_size_bytes(size),
    .req_ready(rdy[0]), .resp_valid(rv[0]), .resp_size_bytes(rs[0]),
    .cfg_latency_sram(cfg_s), .cfg_latency_dram(cfg_d), .cfg_dram_hit_milli_pct(hit),
    .cfg_use_cfg_latencies(use_cfg), .total_reqs(treq[0]), .total_resp(tresp[0]),
    .sram_reqs(sreq[0]), .dram_reqs(dreq[0]), .stall_cycles(stallc[0]),
    .busy_cycles(busyc[0]), .busy(bsy[0]));

  mem_latency_injector #(.SIZE_WIDTH(16), .LATENCY_SRAM_CYCLES(5), .LATENCY_DRAM_CYCLES(12),
    .QUEUE_DEPTH(4), .EXTRA_LATENCY_MAX(0), .LATENCY_DIST_MODE(0)) u1 (
    .clk(clk), .reset(rst_n), .req_valid(vld[1]), .req_is_dram(is_dram), .req_size_bytes(size),
    .req_ready(rdy[1]), .resp_valid(rv[1]), .resp_size_bytes(rs[1]),
    .cfg_latency_sram(cfg_s), .cfg_latency_dram(cfg_d), .cfg_dram_hit_milli_pct(hit),
    .cfg_use_cfg_latencies(use_cfg), .total_reqs(treq[1]), .total_resp(tresp[1]),
    .sram_reqs(sreq[1]), .dram_reqs(dreq[1]), .stall_cycles(stallc[1]),
    .busy_cycles(busyc[1]), .busy(bsy[1]));

  mem_latency_injector #(.SIZE_WIDTH(16), .LATENCY_SRAM_CYCLES(5), .LATENCY_DRAM_CYCLES(12),
    .QUEUE_DEPTH(1), .EXTRA_LATENCY_MAX(8), .LATENCY_DIST_MODE(1)) u2 (
    .clk(clk), .reset(rst_n), .req_valid(vld[2]), .req_is_dram(is_dram), .req_size_bytes(size),
    .req_ready(rdy[2]), .resp_valid(rv[2]), .resp_size_bytes(rs[2]),
    .cfg_latency_sram(cfg_s), .cfg_latency_dram(cfg_d), .cfg_dram_hit_milli_pct(hit),
    .cfg_use_cfg_latencies(use_cfg), .total_reqs(treq[2]), .total_resp(tresp[2]),
    .sram_reqs(sreq[2]), .dram_reqs(dreq[2]), .stall_cycles(stallc[2]),
    .busy_cycles(busyc[2]), .busy(bsy[2]));

  int          depth_p [N] = '{1, 4, 1};
  int          extra_p [N] = '{0, 0, 8};

  int          nvec = 0;
  int          nerr = 0;
  int          act;
  int unsigned edge_n;
  logic [15:0] lfsr_m;
  int          occ_m;
  bit          m_rv;
  ent_t        q[$];
  int unsigned m_treq [N], m_tresp [N], m_sreq [N], m_dreq [N], m_stall [N], m_busy [N];
  logic [15:0] m_rs   [N];

  int unsigned dacc[$];
  int unsigned obs_e[$];
  logic [15:0] obs_sz[$];
  int          lat_last, lat_min, lat_max, lat_cnt;
  int          lat_hist [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  function automatic int calc_lat(input int k, input logic [15:0] lf);
    int  s, d, base;
    bit  h;
    s    = use_cfg ? int'(cfg_s) : 5;
    d    = use_cfg ? int'(cfg_d) : 12;
    h    = (int'(lf[9:0]) % 1000) < int'(hit);
    base = (is_dram && !h) ? d : s;
    if (base == 0) base = 1;
    return base + ((extra_p[k] > 0) ? (int'(lf) % (extra_p[k] + 1)) : 0);
  endfunction

  task automatic model_clear();
    q.delete();
    dacc.delete();
    occ_m  = 0;
    m_rv   = 0;
    lfsr_m = 16'hACE1;
    for (int k = 0; k < N; k++) begin
      m_treq[k] = 0; m_tresp[k] = 0; m_sreq[k] = 0; m_dreq[k] = 0;
      m_stall[k] = 0; m_busy[k] = 0; m_rs[k] = '0;
    end
  endtask

  task automatic check_outs(input int k);
    chk($sformatf("ready%0d", k), rdy[k], (occ_m < depth_p[k]));
    chk($sformatf("resp_valid%0d", k), rv[k], m_rv);
    chk($sformatf("resp_size%0d", k), rs[k], m_rs[k]);
    chk($sformatf("busy%0d", k), bsy[k], (occ_m != 0));
    chk($sformatf("total_reqs%0d", k), treq[k], m_treq[k]);
    chk($sformatf("total_resp%0d", k), tresp[k], m_tresp[k]);
    chk($sformatf("sram_reqs%0d", k), sreq[k], m_sreq[k]);
    chk($sformatf("dram_reqs%0d", k), dreq[k], m_dreq[k]);
    chk($sformatf("stall_cycles%0d", k), stallc[k], m_stall[k]);
    chk($sformatf("busy_cycles%0d", k), busyc[k], m_busy[k]);
  endtask

  // One clock: model the upcoming edge from the current inputs, then compare.
  task automatic tick();
    int          k, lat;
    bit          ready_m, acc, pop;
    ent_t        e;
    k   = act;
    acc = 0;
    pop = 0;
    if (rst_n) begin
      ready_m = (occ_m < depth_p[k]);
      acc     = vld[k] && ready_m;
      if (vld[k] && !ready_m) m_stall[k]++;
      if (occ_m != 0) m_busy[k]++;
      if (q.size() > 0 && q[0].t == edge_n) pop = 1;
      if (acc) begin
        e.acc_e = edge_n;
        e.t     = edge_n + calc_lat(k, lfsr_m) + 1;
        if (q.size() > 0 && q[$].t >= e.t) e.t = q[$].t + 1;
        e.sz    = size;
        q.push_back(e);
        m_treq[k]++;
        if (is_dram) m_dreq[k]++; else m_sreq[k]++;
      end
      if (rdy[k] && vld[k]) dacc.push_back(edge_n);
    end
    @(posedge clk);
    #1;
    m_rv = 0;
    if (rst_n) begin
      lfsr_m = lfsr_next(lfsr_m);
      if (pop) begin
        m_rv    = 1;
        m_rs[k] = q[0].sz;
        void'(q.pop_front());
        m_tresp[k]++;
      end
      occ_m = occ_m + int'(acc) - int'(pop);
    end
    if (rv[k] === 1'b1 && dacc.size() > 0) begin
      lat      = int'(edge_n - dacc.pop_front());
      lat_last = lat;
      lat_cnt++;
      if (lat < lat_min) lat_min = lat;
      if (lat > lat_max) lat_max = lat;
      if (lat >= 0 && lat < 32) lat_hist[lat]++;
      obs_e.push_back(edge_n);
      obs_sz.push_back(rs[k]);
    end
    edge_n++;
    check_outs(k);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() > 0; i++) tick();
    chk("drain_timeout", q.size(), 0);
    tick();
    tick();
  endtask

  task automatic clear_stats();
    lat_min = 1 << 30;
    lat_max = -1;
    lat_cnt = 0;
    lat_last = -1;
    for (int i = 0; i < 32; i++) lat_hist[i] = 0;
    obs_e.delete();
    obs_sz.delete();
  endtask

  task automatic one_req(input logic [15:0] sz);
    size = sz;
    vld[act] = 1'b1;
    tick();
    vld[act] = 1'b0;
    drain();
  endtask

  initial begin
    int distinct, guard;
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) vld[k] = 1'b0;
    is_dram = 1'b0; size = '0; cfg_s = 16'd5; cfg_d = 16'd12; hit = '0; use_cfg = 1'b0;
    act = 0; edge_n = 0;
    model_clear();
    clear_stats();
    repeat (3) tick();
    for (int k = 0; k < N; k++) check_outs(k);
    rst_n = 1'b1;

    // single SRAM request on the fixed-latency depth-1 instance
    tick();
    clear_stats();
    one_req(16'd64);
    chk("lat_sram_single", lat_last, 6);
    chk("single_total_reqs", treq[0], 1);
    chk("single_total_resp", tresp[0], 1);
    chk("single_sram_reqs", sreq[0], 1);

    // held request valid while an entry is outstanding
    vld[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      size = 16'($urandom);
      tick();
    end
    vld[0] = 1'b0;
    drain();

    // runtime latencies: DRAM miss, DRAM hit, zero clamp
    use_cfg = 1'b1; cfg_d = 16'd20; cfg_s = 16'd7; hit = 10'd0; is_dram = 1'b1;
    clear_stats();
    one_req(16'd128);
    chk("lat_dram_miss", lat_last, 21);
    chk("dram_reqs_one", dreq[0], 1);
    hit = 10'd1000;
    clear_stats();
    one_req(16'd256);
    chk("lat_dram_hit", lat_last, 8);
    cfg_s = 16'd0; is_dram = 1'b0;
    clear_stats();
    one_req(16'd32);
    chk("lat_clamp", lat_last, 2);

    // random traffic on instance 0
    for (int i = 0; i < 200; i++) begin
      vld[0]  = ($urandom_range(0, 99) < 60);
      is_dram = 1'($urandom);
      hit     = 10'($urandom_range(0, 1000));
      use_cfg = 1'($urandom);
      cfg_s   = 16'($urandom_range(0, 15));
      cfg_d   = 16'($urandom_range(0, 15));
      size    = 16'($urandom);
      tick();
    end
    vld[0] = 1'b0;
    drain();

    // depth-4 instance: four back-to-back requests, responses on consecutive cycles
    act = 1; use_cfg = 1'b0; is_dram = 1'b0;
    clear_stats();
    vld[1] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      size = 16'(4 * i);
      tick();
    end
    vld[1] = 1'b0;
    drain();
    chk("burst_count", obs_sz.size(), 4);
    if (obs_sz.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("burst_size%0d", i), obs_sz[i], 4 * (i + 1));
        chk($sformatf("burst_edge%0d", i), obs_e[i] - obs_e[0], i);
      end
    end

    // random traffic on instance 1
    for (int i = 0; i < 300; i++) begin
      vld[1]  = ($urandom_range(0, 99) < 70);
      is_dram = 1'($urandom);
      hit     = 10'($urandom_range(0, 1000));
      use_cfg = 1'($urandom);
      cfg_s   = 16'($urandom_range(0, 12));
      cfg_d   = 16'($urandom_range(0, 12));
      size    = 16'($urandom);
      tick();
    end
    vld[1] = 1'b0;
    drain();

    // uniform extra latency: 120 back-to-back SRAM requests
    act = 2; use_cfg = 1'b0; is_dram = 1'b0;
    clear_stats();
    vld[2] = 1'b1;
    guard = 0;
    while (m_treq[2] < 120 && guard < 3000) begin
      size = 16'($urandom);
      tick();
      guard++;
    end
    vld[2] = 1'b0;
    chk("extra_accept_timeout", m_treq[2], 120);
    drain();
    chk("extra_total_resp", tresp[2], 120);
    chk("extra_lat_count", lat_cnt, 120);
    chk("extra_lat_min_ok", (lat_min >= 6), 1);
    chk("extra_lat_max_ok", (lat_max <= 14), 1);
    distinct = 0;
    for (int i = 0; i < 32; i++) if (lat_hist[i] != 0) distinct++;
    chk("extra_lat_distinct", (distinct > 1), 1);

    // reset with two entries outstanding
    act = 1;
    vld[1] = 1'b1;
    size = 16'd100; tick();
    size = 16'd200; tick();
    vld[1] = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    model_clear();
    for (int k = 0; k < N; k++) check_outs(k);
    repeat (2) tick();
    rst_n = 1'b1;
    clear_stats();
    repeat (30) tick();
    chk("post_reset_no_resp", obs_e.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
